// File: rtl/pio_shoot_pulse_if.sv
// Avalon-MM write-side slave bus for the shoot pulse PIO.
interface pio_shoot_pulse_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/pio_shoot_pulse.sv
// Kicker/chipper discharge PIO: one armed pulse of programmable width per FIRE
// write, followed by a mandatory cooldown. Optional irq port under SHOOT_IRQ_EN.
module pio_shoot_pulse #(
  parameter int unsigned      CNT_W        = 16,
  parameter logic [CNT_W-1:0] MAX_PULSE    = CNT_W'(50000),
  parameter logic [CNT_W-1:0] COOLDOWN_RST = CNT_W'(10000)
) (
  input  logic             clk,
  input  logic             reset_n,
  pio_shoot_pulse_if.slave bus,
  output logic             out_port
`ifdef SHOOT_IRQ_EN
  ,
  output logic             irq
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_FIRE, ST_COOL} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_pulse_cnt, w_pulse_nxt;
  logic [CNT_W-1:0] r_cool_cnt, w_cool_nxt;
  logic [CNT_W-1:0] r_cooldown, w_cooldown_nxt;
  logic             r_arm, w_arm_nxt;
  logic             r_dropped, w_dropped_nxt;
  logic             r_irq_pend, w_irq_pend_nxt;
  logic             r_out, w_out_nxt;
  logic [31:0]      r_rdata, w_rdata;

  logic             w_wr, w_fire_wr, w_cool_wr, w_ctrl_wr, w_stat_wr, w_abort;
  logic [CNT_W-1:0] w_wdata, w_req;
  logic             w_unused_wd;

  // Write decode; abort covers both the abort bit and a disarming CTRL write.
  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_fire_wr   = w_wr && (bus.address == 2'd0);
  assign w_cool_wr   = w_wr && (bus.address == 2'd1);
  assign w_ctrl_wr   = w_wr && (bus.address == 2'd2);
  assign w_stat_wr   = w_wr && (bus.address == 2'd3);
  assign w_wdata     = bus.writedata[CNT_W-1:0];
  assign w_req       = (w_wdata > MAX_PULSE) ? MAX_PULSE : w_wdata;
  assign w_abort     = w_ctrl_wr && (bus.writedata[1] || !bus.writedata[0]);
  assign w_unused_wd = ^bus.writedata[31:CNT_W];

  // Next-state, counters, flags and read mux.
  always_comb begin
    w_state_nxt    = r_state;
    w_pulse_nxt    = r_pulse_cnt;
    w_cool_nxt     = r_cool_cnt;
    w_cooldown_nxt = r_cooldown;
    w_arm_nxt      = r_arm;
    w_dropped_nxt  = r_dropped;
    w_irq_pend_nxt = r_irq_pend;
    w_out_nxt      = r_out;

    if (w_cool_wr) w_cooldown_nxt = w_wdata;
    if (w_ctrl_wr) w_arm_nxt = bus.writedata[0];
    // Clears first so a same-cycle hardware set is never lost.
    if (w_stat_wr && bus.writedata[2]) w_dropped_nxt  = 1'b0;
    if (w_stat_wr && bus.writedata[3]) w_irq_pend_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_fire_wr && (w_req != '0)) begin
          if (r_arm) begin
            w_state_nxt = ST_FIRE;
            w_pulse_nxt = w_req;
            w_out_nxt   = 1'b1;
          end else begin
            w_dropped_nxt = 1'b1;
          end
        end
      end
      ST_FIRE: begin
        if (w_fire_wr) w_dropped_nxt = 1'b1;
        if (w_abort) begin
          // Aborted pulses always serve the full cooldown.
          w_state_nxt = ST_COOL;
          w_pulse_nxt = '0;
          w_cool_nxt  = r_cooldown;
          w_out_nxt   = 1'b0;
        end else if (r_pulse_cnt <= CNT_W'(1)) begin
          w_pulse_nxt = '0;
          w_cool_nxt  = r_cooldown;
          w_out_nxt   = 1'b0;
          if (r_cooldown == '0) begin
            w_state_nxt    = ST_IDLE;
            w_irq_pend_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_COOL;
          end
        end else begin
          w_pulse_nxt = r_pulse_cnt - CNT_W'(1);
        end
      end
      ST_COOL: begin
        if (w_fire_wr) w_dropped_nxt = 1'b1;
        if (r_cool_cnt <= CNT_W'(1)) begin
          w_state_nxt    = ST_IDLE;
          w_cool_nxt     = '0;
          w_irq_pend_nxt = 1'b1;
        end else begin
          w_cool_nxt = r_cool_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_out_nxt   = 1'b0;
      end
    endcase

    case (bus.address)
      2'd0:    w_rdata = 32'(r_pulse_cnt);
      2'd1:    w_rdata = 32'(r_cooldown);
      2'd2:    w_rdata = {31'b0, r_arm};
      default: w_rdata = {28'b0, r_irq_pend, r_dropped,
                          r_state == ST_COOL, r_state == ST_FIRE};
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pulse_cnt <= '0;
      r_cool_cnt  <= '0;
      r_cooldown  <= COOLDOWN_RST;
      r_arm       <= 1'b0;
      r_dropped   <= 1'b0;
      r_irq_pend  <= 1'b0;
      r_out       <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pulse_cnt <= w_pulse_nxt;
      r_cool_cnt  <= w_cool_nxt;
      r_cooldown  <= w_cooldown_nxt;
      r_arm       <= w_arm_nxt;
      r_dropped   <= w_dropped_nxt;
      r_irq_pend  <= w_irq_pend_nxt;
      r_out       <= w_out_nxt;
      r_rdata     <= w_rdata;
    end
  end

  assign out_port     = r_out;
  assign bus.readdata = r_rdata;

`ifdef SHOOT_IRQ_EN
  logic r_irq;

  // Level interrupt, registered from the post-edge pending and arm values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= w_irq_pend_nxt & w_arm_nxt;
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_pio_shoot_pulse.sv
// Directed self-checking bench for pio_shoot_pulse.
`timescale 1ns/1ps
module tb_pio_shoot_pulse;
  logic clk = 1'b0;
  logic reset_n;
  logic out_port;
`ifdef SHOOT_IRQ_EN
  logic irq;
`endif
  int n_checks = 0;
  int n_bad    = 0;

  pio_shoot_pulse_if u_if ();

  pio_shoot_pulse u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (u_if),
    .out_port (out_port)
`ifdef SHOOT_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    u_if.address    = a;
    u_if.writedata  = d;
    u_if.chipselect = 1'b1;
    u_if.write_n    = 1'b0;
    tick();
    u_if.chipselect = 1'b0;
    u_if.write_n    = 1'b1;
  endtask

  // Counts out_port-high samples and STATUS cooling samples over n cycles.
  task automatic run_window(input int n, output int hi, output int cool);
    u_if.address = 2'd3;
    hi   = out_port ? 1 : 0;
    cool = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (out_port) hi++;
      if (u_if.readdata[1]) cool++;
    end
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    u_if.address = a;
    tick();
    d = u_if.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_checks++;
    if (out_port !== 1'b0) begin n_bad++; $display("FAIL reset_out got=%b want=0", out_port); end
    read_reg(2'd1, d);
    n_checks++;
    if (d !== 32'd10000) begin n_bad++; $display("FAIL reset_cooldown got=%0d want=10000", d); end
    read_reg(2'd3, d);
    n_checks++;
    if (d !== 32'd0) begin n_bad++; $display("FAIL reset_status got=%h want=0", d); end
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'd0) begin n_bad++; $display("FAIL reset_arm got=%h want=0", d); end
  endtask

  task automatic test_basic_pulse();
    int hi, cool;
    bus_write(2'd2, 32'h1);
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'd3);
    run_window(12, hi, cool);
    n_checks++;
    if (hi !== 3) begin n_bad++; $display("FAIL basic_width got=%0d want=3", hi); end
    n_checks++;
    if (cool !== 5) begin n_bad++; $display("FAIL basic_cool got=%0d want=5", cool); end
    n_checks++;
    if (u_if.readdata[3:0] !== 4'b1000) begin n_bad++; $display("FAIL basic_status got=%b want=1000", u_if.readdata[3:0]); end
`ifdef SHOOT_IRQ_EN
    n_checks++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL basic_irq got=%b want=1", irq); end
`endif
    bus_write(2'd3, 32'h8);
    run_window(1, hi, cool);
    n_checks++;
    if (u_if.readdata[3:0] !== 4'b0000) begin n_bad++; $display("FAIL basic_clear got=%b want=0000", u_if.readdata[3:0]); end
`ifdef SHOOT_IRQ_EN
    n_checks++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL basic_irq_clear got=%b want=0", irq); end
`endif
  endtask

  task automatic test_clamp();
    int hi, cool;
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'd60000);
    run_window(50010, hi, cool);
    n_checks++;
    if (hi !== 50000) begin n_bad++; $display("FAIL clamp_width got=%0d want=50000", hi); end
    n_checks++;
    if (cool !== 2) begin n_bad++; $display("FAIL clamp_cool got=%0d want=2", cool); end
    bus_write(2'd3, 32'h8);
  endtask

  task automatic test_busy_and_disarm();
    int hi, cool;
    // Fire request while cooling.
    bus_write(2'd1, 32'd5);
    bus_write(2'd0, 32'd3);
    tick(); tick(); tick();
    bus_write(2'd0, 32'd10);
    run_window(10, hi, cool);
    n_checks++;
    if (hi !== 0) begin n_bad++; $display("FAIL busy_cool_out got=%0d want=0", hi); end
    n_checks++;
    if (u_if.readdata[3:0] !== 4'b1100) begin n_bad++; $display("FAIL busy_cool_status got=%b want=1100", u_if.readdata[3:0]); end
    bus_write(2'd3, 32'h4);
    run_window(1, hi, cool);
    n_checks++;
    if (u_if.readdata[3:0] !== 4'b1000) begin n_bad++; $display("FAIL dropped_clear got=%b want=1000", u_if.readdata[3:0]); end
    bus_write(2'd3, 32'h8);
    // Fire request while firing: no queuing, original width kept.
    bus_write(2'd0, 32'd5);
    bus_write(2'd0, 32'd9);
    run_window(15, hi, cool);
    n_checks++;
    if (hi + 1 !== 5) begin n_bad++; $display("FAIL busy_fire_width got=%0d want=5", hi + 1); end
    n_checks++;
    if (u_if.readdata[3:0] !== 4'b1100) begin n_bad++; $display("FAIL busy_fire_status got=%b want=1100", u_if.readdata[3:0]); end
    bus_write(2'd3, 32'hC);
    // Disarmed fire request.
    bus_write(2'd2, 32'h0);
    bus_write(2'd0, 32'd4);
    run_window(5, hi, cool);
    n_checks++;
    if (hi !== 0) begin n_bad++; $display("FAIL disarmed_out got=%0d want=0", hi); end
    n_checks++;
    if (u_if.readdata[3:0] !== 4'b0100) begin n_bad++; $display("FAIL disarmed_status got=%b want=0100", u_if.readdata[3:0]); end
    bus_write(2'd3, 32'h4);
    // Zero-width request while armed: ignored without flag.
    bus_write(2'd2, 32'h1);
    bus_write(2'd0, 32'd0);
    run_window(3, hi, cool);
    n_checks++;
    if (hi !== 0 || u_if.readdata[3:0] !== 4'b0000) begin
      n_bad++; $display("FAIL zero_req got_hi=%0d status=%b want 0/0000", hi, u_if.readdata[3:0]);
    end
  endtask

  task automatic test_abort();
    int hi, cool;
    logic [31:0] d;
    bus_write(2'd1, 32'd6);
    bus_write(2'd0, 32'd100);
    repeat (19) tick();
    n_checks++;
    if (out_port !== 1'b1) begin n_bad++; $display("FAIL abort_pre got=%b want=1", out_port); end
    bus_write(2'd2, 32'h3);
    n_checks++;
    if (out_port !== 1'b0) begin n_bad++; $display("FAIL abort_out got=%b want=0", out_port); end
    run_window(12, hi, cool);
    n_checks++;
    if (hi !== 0 || cool !== 6) begin n_bad++; $display("FAIL abort_cool got_hi=%0d cool=%0d want 0/6", hi, cool); end
    n_checks++;
    if (u_if.readdata[3:0] !== 4'b1000) begin n_bad++; $display("FAIL abort_status got=%b want=1000", u_if.readdata[3:0]); end
    bus_write(2'd3, 32'h8);
    // Disarm mid-pulse behaves as abort and clears arm.
    bus_write(2'd0, 32'd50);
    repeat (4) tick();
    bus_write(2'd2, 32'h0);
    n_checks++;
    if (out_port !== 1'b0) begin n_bad++; $display("FAIL disarm_out got=%b want=0", out_port); end
    run_window(10, hi, cool);
    n_checks++;
    if (cool !== 6) begin n_bad++; $display("FAIL disarm_cool got=%0d want=6", cool); end
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'd0) begin n_bad++; $display("FAIL disarm_arm got=%h want=0", d); end
    bus_write(2'd3, 32'h8);
    // Abort in IDLE does nothing.
    bus_write(2'd2, 32'h3);
    run_window(3, hi, cool);
    n_checks++;
    if (cool !== 0 || u_if.readdata[3:0] !== 4'b0000) begin
      n_bad++; $display("FAIL idle_abort got_cool=%0d status=%b want 0/0000", cool, u_if.readdata[3:0]);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int hi, cool;
    logic [31:0] d;
    bus_write(2'd2, 32'h1);
    bus_write(2'd1, 32'd4);
    bus_write(2'd0, 32'd10);
    repeat (6) tick();
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_port !== 1'b0) begin n_bad++; $display("FAIL async_reset_out got=%b want=0", out_port); end
    #3 reset_n = 1'b1;
    tick();
    read_reg(2'd2, d);
    n_checks++;
    if (d !== 32'd0) begin n_bad++; $display("FAIL post_reset_arm got=%h want=0", d); end
    read_reg(2'd3, d);
    n_checks++;
    if (d !== 32'd0) begin n_bad++; $display("FAIL post_reset_status got=%h want=0", d); end
    read_reg(2'd1, d);
    n_checks++;
    if (d !== 32'd10000) begin n_bad++; $display("FAIL post_reset_cooldown got=%0d want=10000", d); end
`ifdef SHOOT_IRQ_EN
    n_checks++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL post_reset_irq got=%b want=0", irq); end
    bus_write(2'd2, 32'h1);
    bus_write(2'd1, 32'd2);
    bus_write(2'd0, 32'd2);
    run_window(8, hi, cool);
    n_checks++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL rearm_irq got=%b want=1", irq); end
`else
    run_window(2, hi, cool);
    n_checks++;
    if (hi !== 0) begin n_bad++; $display("FAIL post_reset_out got=%0d want=0", hi); end
`endif
  endtask

  initial begin
    reset_n         = 1'b0;
    u_if.address    = 2'd0;
    u_if.chipselect = 1'b0;
    u_if.write_n    = 1'b1;
    u_if.writedata  = 32'd0;
    #22 reset_n = 1'b1;
    tick();
    test_reset();
    test_basic_pulse();
    test_clamp();
    test_busy_and_disarm();
    test_abort();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule

// File: doc/pio_shoot_pulse.md
Name: pio_shoot_pulse

Overview:
Avalon-MM write-side slave PIO that drives the kicker/chipper discharge line (out_port) from the Nios core.
- A CPU write arms a single pulse of programmable width in clk cycles.
- Each pulse is followed by an enforced cooldown during which re-fire requests are rejected.
- It is the output counterpart of the read-only shoot-status input PIO and sits on the same system bus.

Parameters:
- CNT_W, 16, width of pulse and cooldown counters.
- MAX_PULSE, 16'd50000, hard clamp on pulse width (cycles); larger requests are truncated to this value.
- COOLDOWN_RST, 16'd10000, reset value of the cooldown register.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- out_port  out  1  shoot drive, active high
- irq  out  1  cooldown-done interrupt (only with SHOOT_IRQ_EN; otherwise the port is absent)

Behaviour:
- Reset values:
  - out_port=0, readdata=0, irq=0.
  - state=IDLE, pulse_cnt=0, cool_cnt=0, cooldown_reg=COOLDOWN_RST.
  - arm=0, dropped=0, irq_pend=0.
- Clocking: all logic is on posedge clk, with asynchronous clear on negedge reset_n. Reset mid-pulse drops out_port immediately and asynchronously.
- Write strobe: wr = chipselect & ~write_n. Writes take effect on the next clock edge.
- Register map, write side:
  - addr0 FIRE: request = writedata[CNT_W-1:0], clamped to MAX_PULSE.
  - addr1 COOLDOWN: cooldown_reg = writedata[CNT_W-1:0].
  - addr2 CTRL: bit0 = arm, bit1 = abort (self-clearing; never stored).
  - addr3 STATUS: writing 1 clears the bit. bit2 clears dropped, bit3 clears irq_pend.
- Register map, read side: readdata is updated every clock from the address mux, with 1-cycle latency and no read strobe.
  - addr0: {zero, pulse_cnt}
  - addr1: {zero, cooldown_reg}
  - addr2: {31'b0, arm}
  - addr3: {28'b0, irq_pend, dropped, state==COOL, state==FIRE}
- FSM state IDLE:
  - A FIRE write with arm=1 and request != 0 sets pulse_cnt=request, state=FIRE, out_port=1 (all at the same edge).
  - A FIRE write with request=0 is ignored with no flag.
  - A FIRE write with arm=0 is ignored and sets dropped=1.
- FSM state FIRE:
  - out_port stays high for exactly request cycles; pulse_cnt decrements each cycle.
  - At the edge where pulse_cnt==1: out_port=0, pulse_cnt=0, cool_cnt=cooldown_reg.
  - The FSM then goes to COOL, or straight to IDLE if cooldown_reg==0. When going straight to IDLE, irq_pend is set.
- FSM state COOL:
  - cool_cnt decrements each cycle.
  - At the edge where cool_cnt==1, the FSM goes to IDLE and irq_pend=1.
- Busy rule: a FIRE write in FIRE or COOL, including the last cycle of either, is ignored and sets dropped=1. No queuing.
- Abort, or a CTRL write with bit0=0 (disarm) while in FIRE: out_port=0 next edge, pulse_cnt=0, and the FSM enters COOL with cool_cnt=cooldown_reg. This is a safety requirement: the cooldown is never skipped.
- Abort or disarm while in COOL or IDLE: no state change.
- Writing cooldown_reg during COOL affects only the next cooldown, not the running one.
- out_port is driven only from a flop, never combinational, so there are no glitches on the kicker gate driver.

Optional Feature:
- Macro: SHOOT_IRQ_EN.
- Defined: irq port exists; irq = irq_pend & arm. irq is level-sensitive and held until cleared through STATUS bit3.
- Undefined: the port is absent and irq_pend is still readable in STATUS. Polling-only software is supported unchanged.

Test Plan:
- Reset, then read addr1 -> readdata=10000 one cycle after address is applied; out_port=0, state IDLE.
- CTRL=1, cooldown=5, FIRE=3 -> out_port high exactly 3 cycles, then STATUS bit1=1 for 5 cycles, then irq_pend=1 and IDLE.
- FIRE=60000 with arm=1 -> out_port high exactly 50000 cycles (clamp).
- FIRE=10 during COOL, and FIRE=4 with arm=0 -> out_port stays 0, dropped=1; STATUS write 0x4 clears it.
- FIRE=100, abort (CTRL=0x3) at cycle 20 -> out_port falls at cycle 21, COOL entered with the full cooldown_reg count.
- Reset_n asserted at pulse cycle 7 of 10 -> out_port=0 asynchronously; after release, IDLE with arm=0. With SHOOT_IRQ_EN, irq stays 0 until re-armed and a new cooldown completes.
